screen_draw_ctrl: RTL and testbench
===================================

// Module: screen_draw_ctrl
// PURPOSE
//  Sequences reads from the full-screen image ROMs (start/game/win/lose, 1-cycle registered read)
//  and turns VGA timing into pixel colour. Drives one shared ROM address bus and selects one ROM's data.
//  Switches screens only at frame boundaries. Sits between vga_timing and the overlay/draw chain.
// PARAMETERS
//  ADDR_WIDTH   20  ROM address width; addr = {vcount[9:0], hcount[9:0]}
//  DATA_WIDTH   12  pixel width, RGB444
//  NUM_SCREENS  4   number of screen ROMs selectable
// PORTS
//  clk          in   1                 pixel clock, posedge active
//  rst          in   1                 synchronous, active-high reset
//  hcount_in    in   11                horizontal pixel counter
//  vcount_in    in   11                vertical line counter
//  hsync_in     in   1                 horizontal sync
//  vsync_in     in   1                 vertical sync
//  hblnk_in     in   1                 horizontal blank
//  vblnk_in     in   1                 vertical blank
//  screen_req   in   2                 requested screen (screen_t), level
//  rom_data_in  in   NUM_SCREENS*DW    packed ROM douts, screen k at [k*DW +: DW]
//  rom_addr     out  ADDR_WIDTH        shared ROM address, registered
//  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out  out  11/11/1/1/1/1  timing delayed 3 cycles
//  rgb_out      out  DATA_WIDTH        pixel colour, registered
//  screen_cur   out  2                 screen currently displayed
//  switch_done  out  1                 1-cycle pulse when a screen switch commits
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; active screen = START (0); switch_done = 0.
//  - Pipeline, timing at cycle n: rom_addr valid n+1; ROM dout valid n+2; rgb_out and all
//    timing outputs valid n+3. Latency is fixed at 3 in every state.
//  - rom_addr = {vcount_in[9:0], hcount_in[9:0]}, registered every cycle in every state.
//    The address is not gated during blanking.
//  - rgb_out = 0 when the delayed hblnk or vblnk is set, or when the state at the pixel's issue cycle was IDLE.
//    Otherwise rgb_out = rom_data_in[sel*DW +: DW], where sel is the active screen delayed 2 cycles.
//    The mux select travels with its pixel, so no frame ever mixes two ROMs.
//  - frame_edge = vblnk_in rising edge, from a 1-cycle registered copy of vblnk_in.
//  - FSM:
//    IDLE:    black output; on frame_edge -> DRAW, and active screen = screen_req.
//    DRAW:    if screen_req != active -> PENDING.
//    PENDING: if screen_req == active -> DRAW with no switch.
//             On frame_edge -> active = screen_req (value sampled that cycle), switch_done = 1, -> DRAW.
//  - Simultaneous events:
//    - frame_edge in DRAW with a new request that same cycle: the switch waits for the next frame_edge.
//    - Request changes again while PENDING: the last value at frame_edge wins.
//  - screen_cur = active screen delayed 3 cycles, aligned with rgb_out.
//  - Reset mid-frame: the pipeline is flushed to 0 and the block returns to IDLE.
//    Black output until the next frame_edge.
//  - screen_req >= NUM_SCREENS is treated as START.
// STRUCTURE
//  - screen_pkg: typedef enum logic [1:0] screen_t {SCR_START, SCR_GAME, SCR_WIN, SCR_LOSE};
//    state_t {ST_IDLE, ST_DRAW, ST_PENDING}; pipeline latency constant ROM_LAT = 3.
//  - One sub-module: delay #(WIDTH, CLK_DEL). It delays the timing bundle, select and IDLE flag, with synchronous rst.
//  - FSM: next-state logic in always_comb, state register in always_ff.
// TESTING
//  1. rst held 5 cycles, then released mid-frame -> rgb_out = 0 until the first vblnk rise,
//     then screen START pixels; screen_cur = 0.
//  2. hcount=5, vcount=3 at cycle n -> rom_addr = 20'h00C05 at n+1;
//     rgb_out = ROM0[0xC05] at n+3; hsync_out equals hsync_in from n.
//  3. DRAW START; screen_req = WIN mid-frame -> rest of frame still START;
//     switch_done pulses 1 cycle at vblnk rise; next frame shows WIN, screen_cur = 2.
//  4. In PENDING, screen_req returns to START before vblnk -> no switch_done; back to DRAW; START kept.
//  5. screen_req: GAME, then LOSE, both within one frame -> at vblnk active = LOSE;
//     exactly one switch_done.
//  6. Blanking region with a nonzero ROM model -> rgb_out = 0 while hblnk_out|vblnk_out,
//     and rom_addr keeps tracking the counters.

Source files
------------

// File: rtl/screen_draw_ctrl_pkg.sv
// Shared types and sizes for the full-screen image draw controller.
package screen_draw_ctrl_pkg;

  localparam int unsigned ADDR_WIDTH  = 20;
  localparam int unsigned DATA_WIDTH  = 12;
  localparam int unsigned NUM_SCREENS = 4;
  localparam int unsigned CNT_WIDTH   = 11;
  localparam int unsigned ROM_LAT     = 3;

  typedef enum logic [1:0] {SCR_START, SCR_GAME, SCR_WIN, SCR_LOSE} screen_t;
  typedef enum logic [1:0] {ST_IDLE, ST_DRAW, ST_PENDING} state_t;

  typedef struct packed {
    logic [CNT_WIDTH-1:0] hcount;
    logic [CNT_WIDTH-1:0] vcount;
    logic                 hsync;
    logic                 vsync;
    logic                 hblnk;
    logic                 vblnk;
  } timing_t;

  // Everything that must travel alongside a pixel while its ROM read is in flight.
  typedef struct packed {
    timing_t timing;
    screen_t sel;
    logic    drawing;
  } pix_tag_t;

  function automatic screen_t sanitize_screen(input screen_t req);
    return (32'(req) < NUM_SCREENS) ? req : SCR_START;
  endfunction

endpackage

// File: rtl/screen_draw_ctrl_if.sv
// VGA timing in/out, screen request and shared ROM bus of the draw controller.
interface screen_draw_ctrl_if;
  import screen_draw_ctrl_pkg::*;

  logic [CNT_WIDTH-1:0]              hcount_in;
  logic [CNT_WIDTH-1:0]              vcount_in;
  logic                              hsync_in;
  logic                              vsync_in;
  logic                              hblnk_in;
  logic                              vblnk_in;
  screen_t                           screen_req;
  logic [NUM_SCREENS*DATA_WIDTH-1:0] rom_data_in;

  logic [ADDR_WIDTH-1:0]             rom_addr;
  logic [CNT_WIDTH-1:0]              hcount_out;
  logic [CNT_WIDTH-1:0]              vcount_out;
  logic                              hsync_out;
  logic                              vsync_out;
  logic                              hblnk_out;
  logic                              vblnk_out;
  logic [DATA_WIDTH-1:0]             rgb_out;
  screen_t                           screen_cur;
  logic                              switch_done;

  modport master (
    output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
    output screen_req, rom_data_in,
    input  rom_addr, hcount_out, vcount_out, hsync_out, vsync_out,
    input  hblnk_out, vblnk_out, rgb_out, screen_cur, switch_done
  );

  modport slave (
    input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
    input  screen_req, rom_data_in,
    output rom_addr, hcount_out, vcount_out, hsync_out, vsync_out,
    output hblnk_out, vblnk_out, rgb_out, screen_cur, switch_done
  );

endinterface

// File: rtl/screen_draw_ctrl_delay.sv
// Fixed-depth shift register with synchronous flush.
module screen_draw_ctrl_delay #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [CLK_DEL*WIDTH-1:0] sr;

  if (CLK_DEL == 1) begin : g_single
    always_ff @(posedge clk) begin
      if (rst) sr <= '0;
      else     sr <= din;
    end
  end else begin : g_chain
    always_ff @(posedge clk) begin
      if (rst) sr <= '0;
      else     sr <= {sr[(CLK_DEL-1)*WIDTH-1:0], din};
    end
  end

  assign dout = sr[CLK_DEL*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/screen_draw_ctrl.sv
// Reads full-screen image ROMs in step with VGA timing and commits screen
// switches only on vblank rising edges.
module screen_draw_ctrl
  import screen_draw_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  screen_draw_ctrl_if.slave bus
);

  localparam int unsigned AXIS_WIDTH = ADDR_WIDTH / 2;

  state_t   state, state_nx;
  screen_t  active, active_nx, req_c;
  logic     switch_nx;
  logic     vblnk_q;
  logic     frame_edge_c;
  pix_tag_t tag_in, tag_d;
  logic [DATA_WIDTH-1:0] rom_word [NUM_SCREENS];

  assign req_c        = sanitize_screen(bus.screen_req);
  assign frame_edge_c = bus.vblnk_in & ~vblnk_q;

  // Screen selection: a change is only committed on a frame edge.
  always_comb begin
    state_nx  = state;
    active_nx = active;
    switch_nx = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_edge_c) begin
          state_nx  = ST_DRAW;
          active_nx = req_c;
        end
      end
      ST_DRAW: begin
        if (req_c != active) state_nx = ST_PENDING;
      end
      ST_PENDING: begin
        if (req_c == active) begin
          state_nx = ST_DRAW;
        end else if (frame_edge_c) begin
          state_nx  = ST_DRAW;
          active_nx = req_c;
          switch_nx = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      active          <= SCR_START;
      bus.switch_done <= 1'b0;
      vblnk_q         <= 1'b0;
      bus.rom_addr    <= '0;
    end else begin
      state           <= state_nx;
      active          <= active_nx;
      bus.switch_done <= switch_nx;
      vblnk_q         <= bus.vblnk_in;
      bus.rom_addr    <= {bus.vcount_in[AXIS_WIDTH-1:0], bus.hcount_in[AXIS_WIDTH-1:0]};
    end
  end

  // The flag is "drawing" rather than "idle" so a flushed pipeline reads as black.
  assign tag_in = '{
    timing: '{
      hcount: bus.hcount_in,
      vcount: bus.vcount_in,
      hsync:  bus.hsync_in,
      vsync:  bus.vsync_in,
      hblnk:  bus.hblnk_in,
      vblnk:  bus.vblnk_in
    },
    sel:     active,
    drawing: (state != ST_IDLE)
  };

  screen_draw_ctrl_delay #(
    .WIDTH   ($bits(pix_tag_t)),
    .CLK_DEL (ROM_LAT - 1)
  ) u_tag_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (tag_in),
    .dout (tag_d)
  );

  for (genvar g = 0; g < NUM_SCREENS; g++) begin : g_rom_word
    assign rom_word[g] = bus.rom_data_in[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Output stage: ROM data meets its own tag here.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.hcount_out <= '0;
      bus.vcount_out <= '0;
      bus.hsync_out  <= 1'b0;
      bus.vsync_out  <= 1'b0;
      bus.hblnk_out  <= 1'b0;
      bus.vblnk_out  <= 1'b0;
      bus.rgb_out    <= '0;
      bus.screen_cur <= SCR_START;
    end else begin
      bus.hcount_out <= tag_d.timing.hcount;
      bus.vcount_out <= tag_d.timing.vcount;
      bus.hsync_out  <= tag_d.timing.hsync;
      bus.vsync_out  <= tag_d.timing.vsync;
      bus.hblnk_out  <= tag_d.timing.hblnk;
      bus.vblnk_out  <= tag_d.timing.vblnk;
      bus.screen_cur <= tag_d.sel;
      if (tag_d.timing.hblnk || tag_d.timing.vblnk || !tag_d.drawing)
        bus.rgb_out <= '0;
      else
        bus.rgb_out <= rom_word[tag_d.sel];
    end
  end

endmodule

// File: tb/tb_screen_draw_ctrl.sv
// Self-checking bench for screen_draw_ctrl on a reduced 40x20 frame.
module tb_screen_draw_ctrl;
  import screen_draw_ctrl_pkg::*;

  localparam int H_TOT = 40, H_ACT = 32, HS0 = 34, HS1 = 35;
  localparam int V_TOT = 20, V_ACT = 12, VS0 = 14, VS1 = 15;

  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
    logic [1:0]  cur;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  screen_draw_ctrl_if bus();
  screen_draw_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int errors, checks, n_sw;
  int h, v;
  logic [31:0] rom_seed;

  // Reference state: screen shown and whether the first frame edge has passed.
  logic    started, prev_vblnk;
  screen_t m_active, prev_req;
  obs_t    q[$];

  function automatic logic [11:0] rom_val(input int k, input logic [19:0] a);
    logic [31:0] x;
    x = ({12'd0, a} ^ rom_seed) * 32'd40503 + 32'(k) * 32'd7919;
    return x[27:16] | 12'h001;
  endfunction

  function automatic logic [47:0] rom_row(input logic [19:0] a);
    logic [47:0] r;
    for (int k = 0; k < 4; k++) r[k*12 +: 12] = rom_val(k, a);
    return r;
  endfunction

  always @(posedge clk) bus.rom_data_in <= rom_row(bus.rom_addr);

  function automatic obs_t act();
    return {bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.vsync_out,
            bus.hblnk_out, bus.vblnk_out, bus.rgb_out, 2'(bus.screen_cur)};
  endfunction

  task automatic drive_timing();
    bus.hcount_in = 11'(h);
    bus.vcount_in = 11'(v);
    bus.hsync_in  = (h >= HS0 && h <= HS1);
    bus.vsync_in  = (v >= VS0 && v <= VS1);
    bus.hblnk_in  = (h >= H_ACT);
    bus.vblnk_in  = (v >= V_ACT);
  endtask

  // One pixel clock: predicts this pixel, applies frame-level rules, returns
  // what the outputs must show right after this edge.
  task automatic tick(output obs_t e, output logic sw, output logic [19:0] ea);
    obs_t    cur;
    logic    blank;
    screen_t req;
    req = bus.screen_req;
    sw  = 1'b0;
    if (rst) begin
      q.delete();
      repeat (3) q.push_back('0);
      started = 1'b0; m_active = SCR_START; prev_req = SCR_START; prev_vblnk = 1'b0;
      ea = '0;
    end else begin
      ea    = 20'((v % 1024) * 1024 + (h % 1024));
      blank = (h >= H_ACT) || (v >= V_ACT);
      cur   = {11'(h), 11'(v), (h >= HS0 && h <= HS1), (v >= VS0 && v <= VS1),
               (h >= H_ACT), blank && !(h >= H_ACT) || (v >= V_ACT),
               (blank || !started) ? 12'h000 : rom_val(int'(m_active), ea), 2'(m_active)};
      q.push_back(cur);
      if ((v >= V_ACT) && !prev_vblnk) begin
        if (!started) begin
          started  = 1'b1;
          m_active = req;
        end else if (prev_req != m_active && req != m_active) begin
          m_active = req;
          sw       = 1'b1;
        end
      end
      prev_vblnk = (v >= V_ACT);
      prev_req   = req;
    end
    @(posedge clk);
    #1;
    e = q.pop_front();
    h++;
    if (h == H_TOT) begin
      h = 0;
      v = (v + 1) % V_TOT;
    end
    drive_timing();
  endtask

  task automatic test_reset();
    obs_t e; logic sw; logic [19:0] ea; int nz;
    rst = 1'b1;
    repeat (5) begin
      tick(e, sw, ea);
      checks += 2;
      if (act() !== e) begin errors++; $display("FAIL reset_hold actual=%h required=%h", act(), e); end
      if (bus.rom_addr !== ea) begin errors++; $display("FAIL reset_addr actual=%h required=%h", bus.rom_addr, ea); end
    end
    rst = 1'b0;
    nz = 0;
    repeat (1000) begin
      tick(e, sw, ea);
      checks += 3;
      if (act() !== e) begin errors++; $display("FAIL reset_pipe actual=%h required=%h", act(), e); end
      if (bus.switch_done !== sw) begin errors++; $display("FAIL reset_sw actual=%b required=%b", bus.switch_done, sw); end
      if (bus.rom_addr !== ea) begin errors++; $display("FAIL reset_addr actual=%h required=%h", bus.rom_addr, ea); end
      if (bus.rgb_out !== 12'h000) nz++;
    end
    checks += 2;
    if (nz == 0) begin errors++; $display("FAIL reset_start_pixels actual=%0d required=>0", nz); end
    if (bus.screen_cur !== SCR_START) begin errors++; $display("FAIL reset_cur actual=%0d required=0", bus.screen_cur); end
  endtask

  task automatic test_addr();
    obs_t e; logic sw; logic [19:0] ea; logic hs;
    for (int i = 0; i < 2000 && !(h == 5 && v == 3); i++) tick(e, sw, ea);
    hs = bus.hsync_in;
    for (int i = 0; i < 3; i++) begin
      tick(e, sw, ea);
      checks += 1;
      if (act() !== e) begin errors++; $display("FAIL addr_pipe actual=%h required=%h", act(), e); end
      if (i == 0) begin
        checks += 1;
        if (bus.rom_addr !== 20'h00C05) begin errors++; $display("FAIL addr_c05 actual=%h required=00c05", bus.rom_addr); end
      end
    end
    checks += 3;
    if (bus.rgb_out !== rom_val(0, 20'h00C05)) begin errors++; $display("FAIL addr_rgb actual=%h required=%h", bus.rgb_out, rom_val(0, 20'h00C05)); end
    if (bus.hsync_out !== hs) begin errors++; $display("FAIL addr_hsync actual=%b required=%b", bus.hsync_out, hs); end
    if (bus.hcount_out !== 11'd5) begin errors++; $display("FAIL addr_hcount actual=%0d required=5", bus.hcount_out); end
  endtask

  // Runs n cycles with full per-cycle checking; used by the switching scenarios.
  task automatic test_frames(input string name, input int n, input int req_at, input screen_t req_val,
                             input int req2_at, input screen_t req2_val);
    obs_t e; logic sw; logic [19:0] ea;
    for (int i = 0; i < n; i++) begin
      if (i == req_at)  bus.screen_req = req_val;
      if (i == req2_at) bus.screen_req = req2_val;
      tick(e, sw, ea);
      checks += 3;
      if (act() !== e) begin errors++; $display("FAIL %s_pipe actual=%h required=%h", name, act(), e); end
      if (bus.switch_done !== sw) begin errors++; $display("FAIL %s_sw actual=%b required=%b", name, bus.switch_done, sw); end
      if (bus.rom_addr !== ea) begin errors++; $display("FAIL %s_addr actual=%h required=%h", name, bus.rom_addr, ea); end
      if (bus.switch_done === 1'b1) n_sw++;
    end
  endtask

  task automatic test_switch();
    n_sw = 0;
    test_frames("switch", 800, 5, SCR_WIN, -1, SCR_WIN);
    checks += 2;
    if (n_sw !== 1) begin errors++; $display("FAIL switch_count actual=%0d required=1", n_sw); end
    if (bus.screen_cur !== SCR_WIN) begin errors++; $display("FAIL switch_cur actual=%0d required=2", bus.screen_cur); end
  endtask

  task automatic test_cancel();
    n_sw = 0;
    test_frames("cancel", 800, 0, SCR_GAME, 50, SCR_WIN);
    checks += 2;
    if (n_sw !== 0) begin errors++; $display("FAIL cancel_count actual=%0d required=0", n_sw); end
    if (bus.screen_cur !== SCR_WIN) begin errors++; $display("FAIL cancel_cur actual=%0d required=2", bus.screen_cur); end
  endtask

  task automatic test_last_wins();
    n_sw = 0;
    test_frames("last", 800, 0, SCR_GAME, 100, SCR_LOSE);
    checks += 2;
    if (n_sw !== 1) begin errors++; $display("FAIL last_count actual=%0d required=1", n_sw); end
    if (bus.screen_cur !== SCR_LOSE) begin errors++; $display("FAIL last_cur actual=%0d required=3", bus.screen_cur); end
  endtask

  task automatic test_edge_request();
    obs_t e; logic sw; logic [19:0] ea;
    for (int i = 0; i < 2000 && !(h == 0 && v == V_ACT); i++) tick(e, sw, ea);
    n_sw = 0;
    bus.screen_req = SCR_START;
    tick(e, sw, ea);
    checks += 1;
    if (bus.switch_done !== 1'b0) begin errors++; $display("FAIL edge_same_cycle actual=%b required=0", bus.switch_done); end
    test_frames("edge", 810, -1, SCR_START, -1, SCR_START);
    checks += 2;
    if (n_sw !== 1) begin errors++; $display("FAIL edge_count actual=%0d required=1", n_sw); end
    if (bus.screen_cur !== SCR_START) begin errors++; $display("FAIL edge_cur actual=%0d required=0", bus.screen_cur); end
  endtask

  task automatic test_random_blank();
    obs_t e; logic sw; logic [19:0] ea; int nblank;
    nblank = 0;
    for (int i = 0; i < 3400; i++) begin
      if ($urandom_range(199, 0) == 0) bus.screen_req = screen_t'(2'($urandom_range(3, 0)));
      rst = (i >= 2500 && i < 2503);
      tick(e, sw, ea);
      checks += 3;
      if (act() !== e) begin errors++; $display("FAIL rand_pipe actual=%h required=%h", act(), e); end
      if (bus.switch_done !== sw) begin errors++; $display("FAIL rand_sw actual=%b required=%b", bus.switch_done, sw); end
      if (bus.rom_addr !== ea) begin errors++; $display("FAIL rand_addr actual=%h required=%h", bus.rom_addr, ea); end
      if (bus.hblnk_out === 1'b1 || bus.vblnk_out === 1'b1) begin
        nblank++;
        checks += 1;
        if (bus.rgb_out !== 12'h000) begin errors++; $display("FAIL blank_rgb actual=%h required=000", bus.rgb_out); end
      end
    end
    rst = 1'b0;
    checks += 1;
    if (nblank == 0) begin errors++; $display("FAIL blank_seen actual=0 required=>0"); end
  endtask

  initial begin
    errors = 0; checks = 0; n_sw = 0;
    rom_seed = $urandom;
    rst = 1'b1;
    h = 20; v = 5;
    bus.screen_req = SCR_START;
    drive_timing();
    test_reset();
    test_addr();
    test_switch();
    test_cancel();
    test_last_wins();
    test_edge_request();
    test_random_blank();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
